// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher controller: one SUB/MIX cycle pair per round, key from an external store.
// Optional feature macro AES_DEC_BLKCNT_EN adds blk_cnt, a saturating count of delivered blocks.
//   state | meaning
//   IDLE  | ready for a block; initial AddRoundKey with key 10
//   SUB   | registered InvShiftRows + InvSubBytes of the working state
//   MIX   | AddRoundKey(rnd) then InvMixColumns; rnd counts down
//   FINAL | last AddRoundKey with key 0 into the output register
//   DONE  | plaintext held until the consumer takes it
module aes_inv_cipher_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
`ifdef AES_DEC_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUB   = 3'd1,
    MIX   = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] isb_q, isb_d;
  logic [127:0] out_q, out_d;
  logic         in_ready_q, out_valid_q, busy_q;
  logic [3:0]   rk_idx_q, rk_idx_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map, then multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] r;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    isb_d   = isb_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d    = in_block ^ rk;
          rnd_d   = 4'd9;
          state_d = SUB;
        end
      end
      SUB: begin
        isb_d   = inv_shift_sub(st_q);
        state_d = (rnd_q >= 4'd1) ? MIX : FINAL;
      end
      MIX: begin
        st_d    = inv_mix(isb_q ^ rk);
        rnd_d   = (rnd_q != 4'd0) ? rnd_q - 4'd1 : 4'd0;
        state_d = SUB;
      end
      FINAL: begin
        out_d   = isb_q ^ rk;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      SUB, MIX: rk_idx_d = rnd_d;
      FINAL:    rk_idx_d = 4'd0;
      default:  rk_idx_d = 4'd10;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      st_q        <= '0;
      isb_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= 4'd10;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      isb_q       <= isb_d;
      out_q       <= out_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      rk_idx_q    <= rk_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;
  assign out_block = out_q;

`ifdef AES_DEC_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= 16'h0000;
    end else if (out_valid_q && out_ready && (blk_cnt_q != 16'hFFFF)) begin
      blk_cnt_q <= blk_cnt_q + 16'h0001;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: a forward AES-128 model encrypts random plaintexts that the DUT must recover.
// Blocks guarded by AES_DEC_BLKCNT_EN exercise the optional block counter.
module tb_aes_inv_cipher_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
`ifdef AES_DEC_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   sbox   [256];
  logic [127:0] rk_tab [11];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_inv_cipher_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
`ifdef AES_DEC_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    if (rk_idx <= 4'd10) rk = rk_tab[rk_idx];
    else                 rk = '0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Forward S-box from first principles: brute-force field inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    logic [127:0] k;
    k = rk_tab[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[4*c+q] = sbox[s[4*((c+q)%4)+q]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      k = rk_tab[r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block from IDLE with out_ready high; in_valid is kept high with junk while busy.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string tag);
    int n;
    int bad_trace;
    int bad_ctl;
    chk({tag, "_ready"}, 128'(in_ready), 128'd1);
    in_block = ct;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_block  = rand128();
    n         = 0;
    bad_trace = 0;
    bad_ctl   = 0;
    while (!out_valid && n < 40) begin
      if (32'(rk_idx) != 9 - n / 2) bad_trace++;
      if (in_ready || !busy) bad_ctl++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 128'(n), 128'd20);
    chk({tag, "_rk_trace"}, 128'(bad_trace), 128'd0);
    chk({tag, "_busy_ctl"}, 128'(bad_ctl), 128'd0);
    chk({tag, "_rk_done"}, 128'(rk_idx), 128'd10);
    chk({tag, "_out"}, out_block, pt);
    @(posedge clk); #1;
    chk({tag, "_idle"}, 128'({in_ready, busy, out_valid}), 128'b100);
  endtask

  initial begin
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] pts [3];
    int           n;
    int           bad;
    int           acc_t [3];
    int           n_acc;
    int           n_out;
    logic         acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b1;
    build_sbox();
    expand_key(C1_KEY);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd10);
    chk("rst_out_block", out_block, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_block(C1_CT, C1_PT, "c1");

    for (int k = 0; k < 4; k++) begin
      key = rand128();
      expand_key(key);
      pt = rand128();
      run_block(encrypt(pt), pt, "rand");
    end

    // Back-pressure: hold DONE for 50 cycles with a competing in_valid.
    key = rand128();
    expand_key(key);
    pt        = rand128();
    ct        = encrypt(pt);
    out_ready = 1'b0;
    in_block  = ct;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_block = rand128();
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 128'(n), 128'd20);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!out_valid || out_block !== pt || in_ready || !busy) bad++;
      @(posedge clk); #1;
    end
    chk("bp_hold", 128'(bad), 128'd0);
    chk("bp_out", out_block, pt);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 128'({in_ready, busy, out_valid}), 128'b100);

    // Back-to-back: in_valid held high across three blocks.
    key = rand128();
    expand_key(key);
    for (int i = 0; i < 3; i++) pts[i] = rand128();
    for (int i = 0; i < 3; i++) acc_t[i] = 0;
    n_acc    = 0;
    n_out    = 0;
    in_block = encrypt(pts[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 120 && n_out < 3; c++) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("b2b_out", out_block, pts[n_out]);
        n_out++;
      end
      @(posedge clk); #1;
      if (acc) begin
        acc_t[n_acc] = c;
        n_acc++;
        if (n_acc < 3) in_block = encrypt(pts[n_acc]);
        else           in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_outputs", 128'(n_out), 128'd3);
    chk("b2b_gap01", 128'(acc_t[1] - acc_t[0]), 128'd22);
    chk("b2b_gap12", 128'(acc_t[2] - acc_t[1]), 128'd22);
    @(posedge clk); #1;

    // Reset while rnd=5 (ninth cycle after the accept).
    expand_key(C1_KEY);
    in_block = C1_CT;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("mid_rk_idx", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_state", 128'({in_ready, busy, out_valid}), 128'b100);
    chk("mid_rst_out", out_block, 128'd0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid || busy) bad++;
      @(posedge clk); #1;
    end
    chk("mid_rst_quiet", 128'(bad), 128'd0);
    run_block(C1_CT, C1_PT, "c1_after_rst");

`ifdef AES_DEC_BLKCNT_EN
    run_block(C1_CT, C1_PT, "cnt_b2");
    run_block(C1_CT, C1_PT, "cnt_b3");
    chk("blk_cnt_3", 128'(blk_cnt), 128'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("blk_cnt_rst", 128'(blk_cnt), 128'd0);
    force dut.blk_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.blk_cnt_q;
    run_block(C1_CT, C1_PT, "cnt_sat");
    chk("blk_cnt_sat", 128'(blk_cnt), 128'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
